// File: rtl/uart_sensor_report.sv
`timescale 1ns/1ps
// Periodic multi-channel ASCII report generator over a byte-level TX handshake,
// with UART command decoding (channel select, threshold trim, report request) and hysteretic alarms.
module uart_sensor_report #(
    parameter int CLK_FRE    = 50,
    parameter int PERIOD_MS  = 1000,
    parameter int PERIOD_CYC = CLK_FRE * 1000 * PERIOD_MS,
    parameter int CH_NUM     = 2,
    parameter int DIG_NUM    = 4,
    parameter int THRES_INIT = 40,
    parameter int THRES_MAX  = 99,
    parameter int HYST       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CH_NUM*DIG_NUM*4-1:0]   sensor_bcd,
    input  logic                          sensor_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_en,
    input  logic                          tx_busy,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [CH_NUM-1:0]             alarm,
    output logic [CH_NUM*8-1:0]           thres,
    output logic                          frame_done
);

    localparam logic [31:0] P_PER_LAST = 32'(PERIOD_CYC - 1);
    localparam logic [3:0]  P_CHN      = 4'(CH_NUM);
    localparam logic [3:0]  P_DEND     = 4'(DIG_NUM + 2);
    localparam logic [3:0]  P_COMMA    = 4'(DIG_NUM + 3);
    localparam logic [3:0]  P_TENS     = 4'(DIG_NUM + 4);
    localparam logic [3:0]  P_UNITS    = 4'(DIG_NUM + 5);
    localparam logic [3:0]  P_SEMI     = 4'(DIG_NUM + 6);
    localparam logic [7:0]  P_TMAX     = 8'(THRES_MAX);
    localparam logic [7:0]  P_TINIT    = 8'(THRES_INIT);
    localparam logic [8:0]  P_HYST     = 9'(HYST);

    typedef enum logic [1:0] {S_WAIT, S_LOAD, S_SEND} state_t;

    state_t r_state, w_next;

    logic [CH_NUM-1:0][DIG_NUM-1:0][3:0] w_bcd;
    logic [CH_NUM-1:0][DIG_NUM-1:0][3:0] r_snap_bcd;
    logic [CH_NUM-1:0][7:0]              r_thres;
    logic [CH_NUM-1:0][7:0]              r_snap_thr;
    logic [CH_NUM-1:0][7:0]              w_val;
    logic [CH_NUM-1:0]                   r_alarm;

    logic [31:0] r_cnt;
    logic        r_req;
    logic [3:0]  r_sel;
    logic [3:0]  r_ch;
    logic [3:0]  r_pos;
    logic        r_tx_en;
    logic [7:0]  r_tx_data;
    logic        r_frame_done;

    logic                    w_start;
    logic                    w_issue;
    logic                    w_last;
    logic [7:0]              w_byte;
    logic [DIG_NUM-1:0][3:0] w_ch_bcd;
    logic [7:0]              w_thr_cur;
    logic [3:0]              w_dsel;
    logic [3:0]              w_digit;
    logic [7:0]              w_tens;
    logic [7:0]              w_units;

    logic w_rx_sel, w_rx_inc, w_rx_dec, w_rx_req;

    assign w_bcd      = sensor_bcd;
    assign thres      = r_thres;
    assign alarm      = r_alarm;
    assign tx_en      = r_tx_en;
    assign tx_data    = r_tx_data;
    assign frame_done = r_frame_done;

    // Channel digits share the low nibble of their ASCII code.
    assign w_rx_sel = rx_valid && (rx_data >= 8'h30) && (rx_data <= 8'h39) && (rx_data[3:0] < P_CHN);
    assign w_rx_inc = rx_valid && (rx_data == 8'h2B);
    assign w_rx_dec = rx_valid && (rx_data == 8'h2D);
    assign w_rx_req = rx_valid && (rx_data == 8'h52);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_WAIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:  if (w_start) w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND:  if (w_issue && w_last) w_next = S_WAIT;
            default: w_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_start = (r_state == S_WAIT) && ((r_cnt == P_PER_LAST) || r_req);
        w_issue = (r_state == S_SEND) && !tx_busy && !r_tx_en;
    end

    // Frame position is tracked as (channel, offset); r_ch == CH_NUM selects the CR/LF trailer.
    always_comb begin
        w_ch_bcd  = '0;
        w_thr_cur = '0;
        w_digit   = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (r_ch == 4'(c)) begin
                w_ch_bcd  = r_snap_bcd[c];
                w_thr_cur = r_snap_thr[c];
            end
        end
        w_dsel = P_DEND - r_pos;
        for (int unsigned d = 0; d < DIG_NUM; d++) begin
            if (w_dsel == 4'(d)) w_digit = w_ch_bcd[d];
        end
        w_tens  = w_thr_cur / 8'd10;
        w_units = w_thr_cur % 8'd10;
        w_byte  = 8'h00;
        if (r_ch < P_CHN) begin
            if (r_pos == 4'd0)          w_byte = 8'h43;
            else if (r_pos == 4'd1)     w_byte = 8'h30 + {4'h0, r_ch};
            else if (r_pos == 4'd2)     w_byte = 8'h3D;
            else if (r_pos <= P_DEND)   w_byte = 8'h30 + {4'h0, w_digit};
            else if (r_pos == P_COMMA)  w_byte = 8'h2C;
            else if (r_pos == P_TENS)   w_byte = 8'h30 + w_tens;
            else if (r_pos == P_UNITS)  w_byte = 8'h30 + w_units;
            else                        w_byte = 8'h3B;
        end else begin
            w_byte = (r_pos == 4'd0) ? 8'h0D : 8'h0A;
        end
        w_last = (r_ch == P_CHN) && (r_pos == 4'd1);
    end

    always_comb begin
        w_val = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            w_val[c] = {4'h0, w_bcd[c][DIG_NUM-1]} * 8'd10 + {4'h0, w_bcd[c][DIG_NUM-2]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_ch         <= '0;
            r_pos        <= '0;
            r_tx_en      <= 1'b0;
            r_tx_data    <= '0;
            r_frame_done <= 1'b0;
            r_snap_bcd   <= '0;
            r_snap_thr   <= '0;
        end else begin
            if (w_start)                r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 32'd1;

            if (w_rx_req)     r_req <= 1'b1;
            else if (w_start) r_req <= 1'b0;

            if (r_state == S_LOAD) begin
                r_snap_bcd <= w_bcd;
                r_snap_thr <= r_thres;
                r_ch       <= '0;
                r_pos      <= '0;
            end else if (w_issue) begin
                if (r_ch == P_CHN) begin
                    r_pos <= r_pos + 4'd1;
                end else if (r_pos == P_SEMI) begin
                    r_pos <= '0;
                    r_ch  <= r_ch + 4'd1;
                end else begin
                    r_pos <= r_pos + 4'd1;
                end
            end

            r_tx_en      <= w_issue;
            r_frame_done <= w_issue && w_last;
            if (w_issue) r_tx_data <= w_byte;
        end
    end

    // Alarm compares see the pre-edit threshold when a trim command lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_thres <= {CH_NUM{P_TINIT}};
            r_alarm <= '0;
        end else begin
            if (w_rx_sel) r_sel <= rx_data[3:0];
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                if (r_sel == 4'(c)) begin
                    if (w_rx_inc && (r_thres[c] < P_TMAX))
                        r_thres[c] <= r_thres[c] + 8'd1;
                    else if (w_rx_dec && (r_thres[c] != 8'd0))
                        r_thres[c] <= r_thres[c] - 8'd1;
                end
                if (sensor_valid) begin
                    if (w_val[c] >= r_thres[c])
                        r_alarm[c] <= 1'b1;
                    else if (({1'b0, w_val[c]} + P_HYST) < {1'b0, r_thres[c]})
                        r_alarm[c] <= 1'b0;
                end
            end
        end
    end

endmodule
